// File: rtl/tetris_pkg.sv
// Shared constants and types for the tetris grid reader: geometry, register map, CTRL bits.
package tetris_pkg;

    localparam int unsigned GRID_ROWS   = 20;
    localparam int unsigned GRID_COLS   = 10;
    localparam int unsigned AVS_DATA_W  = 32;
    localparam int unsigned AVS_ADDR_W  = 5;
    localparam int unsigned LINES_W_DEF = 16;
    localparam int unsigned GEN_W       = 8;

    // Control/status words sit directly above the snapshot rows.
    localparam int unsigned OFS_STATUS  = 0;
    localparam int unsigned OFS_LINES   = 1;
    localparam int unsigned OFS_CTRL    = 2;
    localparam int unsigned OFS_GEN     = 3;

    localparam int unsigned ADDR_STATUS = GRID_ROWS + OFS_STATUS;
    localparam int unsigned ADDR_LINES  = GRID_ROWS + OFS_LINES;
    localparam int unsigned ADDR_CTRL   = GRID_ROWS + OFS_CTRL;
    localparam int unsigned ADDR_GEN    = GRID_ROWS + OFS_GEN;

    localparam int unsigned CTRL_SNAP_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_CLR_BIT    = 2;

    typedef enum logic {
        SNAP_IDLE    = 1'b0,
        SNAP_CAPTURE = 1'b1
    } snap_state_t;

endpackage

// File: rtl/tetris_event_counter.sv
// Edge detection on row_cleared/game_over, saturating cleared-line counter and pending flag.
module tetris_event_counter #(
    parameter int unsigned LINES_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               row_cleared_i,
    input  logic               game_over_i,
    input  logic               clr_i,
    output logic [LINES_W-1:0] lines_o,
    output logic               pending_o
);

    logic               row_prev_q;
    logic               go_prev_q;
    logic [LINES_W-1:0] lines_q;
    logic [LINES_W-1:0] lines_d;
    logic               pending_q;
    logic               pending_d;
    logic               row_rise;
    logic               go_rise;

    assign row_rise = row_cleared_i & ~row_prev_q;
    assign go_rise  = game_over_i & ~go_prev_q;

    // Clear is applied first so an event in the same cycle still lands on top of it.
    always_comb begin
        lines_d   = lines_q;
        pending_d = pending_q;
        if (clr_i) begin
            lines_d   = '0;
            pending_d = 1'b0;
        end
        if (row_rise && (lines_d != '1)) begin
            lines_d = lines_d + LINES_W'(1);
        end
        if (row_rise || go_rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_prev_q <= 1'b0;
            go_prev_q  <= 1'b0;
            lines_q    <= '0;
            pending_q  <= 1'b0;
        end else begin
            row_prev_q <= row_cleared_i;
            go_prev_q  <= game_over_i;
            lines_q    <= lines_d;
            pending_q  <= pending_d;
        end
    end

    assign lines_o   = lines_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/tetris_grid_reader.sv
// CPU-side reader: atomic playfield snapshot on request, Avalon-MM register access, line-clear irq.
module tetris_grid_reader
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS    = GRID_ROWS,
    parameter int unsigned COLS    = GRID_COLS,
    parameter int unsigned DATA_W  = AVS_DATA_W,
    parameter int unsigned ADDR_W  = AVS_ADDR_W,
    parameter int unsigned LINES_W = LINES_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] grid_state,
    input  logic                 row_cleared,
    input  logic                 game_over,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [DATA_W-1:0]    avs_writedata,
    output logic [DATA_W-1:0]    avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 avs_waitrequest,
    output logic                 irq
);

    localparam int unsigned       ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W-1:0] A_ROWS    = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(ROWS + OFS_STATUS);
    localparam logic [ADDR_W-1:0] A_LINES   = ADDR_W'(ROWS + OFS_LINES);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ROWS + OFS_CTRL);
    localparam logic [ADDR_W-1:0] A_GEN     = ADDR_W'(ROWS + OFS_GEN);

    snap_state_t               state_q;
    snap_state_t               state_d;
    logic                      snap_load_c;
    logic [ROWS-1:0][COLS-1:0] snap_q;
    logic                      snap_valid_q;
    logic [GEN_W-1:0]          gen_q;
    logic                      irq_en_q;
    logic                      irq_q;
    logic                      waitreq_q;
    logic                      rdvalid_q;
    logic [DATA_W-1:0]         rdata_q;
    logic [DATA_W-1:0]         rdata_c;

    logic                      rd_acc;
    logic                      wr_acc;
    logic                      wr_ctrl;
    logic                      clr;
    logic [ROW_IDX_W-1:0]      row_idx;
    logic [LINES_W-1:0]        lines;
    logic                      pending;
    logic                      unused_wdata;

    // A simultaneous write wins; the read is dropped without a valid pulse.
    assign wr_acc       = avs_write & ~waitreq_q;
    assign rd_acc       = avs_read & ~avs_write & ~waitreq_q;
    assign wr_ctrl      = wr_acc & (avs_address == A_CTRL);
    assign clr          = wr_ctrl & avs_writedata[CTRL_CLR_BIT];
    assign row_idx      = ROW_IDX_W'(avs_address);
    assign unused_wdata = ^avs_writedata[DATA_W-1:CTRL_CLR_BIT+1];

    tetris_event_counter #(
        .LINES_W (LINES_W)
    ) u_events (
        .clk           (clk),
        .rst           (reset),
        .row_cleared_i (row_cleared),
        .game_over_i   (game_over),
        .clr_i         (clr),
        .lines_o       (lines),
        .pending_o     (pending)
    );

    always_comb begin
        state_d     = state_q;
        snap_load_c = 1'b0;
        unique case (state_q)
            SNAP_IDLE: begin
                if (wr_ctrl && avs_writedata[CTRL_SNAP_BIT]) begin
                    state_d = SNAP_CAPTURE;
                end
            end
            SNAP_CAPTURE: begin
                snap_load_c = 1'b1;
                state_d     = SNAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SNAP_IDLE;
            waitreq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitreq_q <= (state_d == SNAP_CAPTURE);
        end
    end

    // Whole frame is loaded in one edge, so the CPU never sees a torn snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            gen_q        <= '0;
        end else if (snap_load_c) begin
            snap_q       <= grid_state;
            snap_valid_q <= 1'b1;
            gen_q        <= gen_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= avs_writedata[CTRL_IRQ_EN_BIT];
            end
            irq_q <= irq_en_q & pending;
        end
    end

    always_comb begin
        rdata_c = '0;
        case (avs_address)
            A_STATUS: rdata_c = DATA_W'({pending, game_over, snap_valid_q});
            A_LINES:  rdata_c = DATA_W'(lines);
            A_CTRL:   rdata_c = DATA_W'({irq_en_q, 1'b0});
            A_GEN:    rdata_c = DATA_W'(gen_q);
            default: begin
                if (avs_address < A_ROWS) begin
                    rdata_c = DATA_W'(snap_q[row_idx]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rdvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= rdata_c;
            end
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdvalid_q;
    assign avs_waitrequest   = waitreq_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_tetris_grid_reader.sv
// Self-checking bench: directed table, hand sequences and randomized ops against a register-level model.
module tb_tetris_grid_reader;
    import tetris_pkg::*;

    localparam int unsigned R = GRID_ROWS;
    localparam int unsigned C = GRID_COLS;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [R*C-1:0]   grid_state;
    logic             row_cleared;
    logic             game_over;
    logic [4:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic             avs_readdatavalid;
    logic             avs_waitrequest;
    logic             irq;
    logic [31:0]      avs_readdata_s;
    logic             unused_rdvalid_s;
    logic             unused_waitreq_s;
    logic             unused_irq_s;

    int               n_checks = 0;
    int               n_fail   = 0;

    logic [C-1:0]     m_snap [R];
    logic             m_snap_valid;
    logic             m_pending;
    logic             m_irq_en;
    int               m_gen;
    int               m_lines;
    int               m_lines_small;

    always #5 clk = ~clk;

    tetris_grid_reader #(
        .ROWS(R), .COLS(C), .DATA_W(32), .ADDR_W(5), .LINES_W(16)
    ) dut (
        .clk(clk), .reset(reset), .grid_state(grid_state),
        .row_cleared(row_cleared), .game_over(game_over),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
        .irq(irq)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    tetris_grid_reader #(
        .ROWS(R), .COLS(C), .DATA_W(32), .ADDR_W(5), .LINES_W(4)
    ) dut_small (
        .clk(clk), .reset(reset), .grid_state(grid_state),
        .row_cleared(row_cleared), .game_over(game_over),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata_s),
        .avs_readdatavalid(unused_rdvalid_s), .avs_waitrequest(unused_waitreq_s),
        .irq(unused_irq_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < R; r++) m_snap[r] = '0;
        m_snap_valid  = 1'b0;
        m_pending     = 1'b0;
        m_irq_en      = 1'b0;
        m_gen         = 0;
        m_lines       = 0;
        m_lines_small = 0;
    endtask

    task automatic model_snapshot();
        for (int r = 0; r < R; r++) m_snap[r] = grid_state[r*C +: C];
        m_snap_valid = 1'b1;
        m_gen        = (m_gen + 1) % 256;
    endtask

    task automatic model_line();
        if (m_lines < 65535) m_lines++;
        if (m_lines_small < 15) m_lines_small++;
        m_pending = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = '0;
        if (a < int'(R))                 v = 32'(m_snap[a]);
        else if (a == int'(ADDR_STATUS)) v = {29'b0, m_pending, game_over, m_snap_valid};
        else if (a == int'(ADDR_LINES))  v = 32'(m_lines);
        else if (a == int'(ADDR_CTRL))   v = {30'b0, m_irq_en, 1'b0};
        else if (a == int'(ADDR_GEN))    v = 32'(m_gen);
        return v;
    endfunction

    // All tasks start just after a falling edge and return on a falling edge.
    task automatic do_read(input int a, output logic [31:0] d, output logic [31:0] d2);
        avs_address = 5'(a);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        check($sformatf("rdvalid_a%0d", a), 32'(avs_readdatavalid), 32'd1);
        d  = avs_readdata;
        d2 = avs_readdata_s;
    endtask

    task automatic read_check(input int a);
        logic [31:0] d, d2;
        do_read(a, d, d2);
        check($sformatf("read_a%0d", a), d, model_read(a));
        if (a == int'(ADDR_LINES)) check("lines_small", d2, 32'(m_lines_small));
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        avs_address   = 5'(a);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
        if (a == int'(ADDR_CTRL)) begin
            m_irq_en = d[1];
            if (d[2]) begin
                m_lines       = 0;
                m_lines_small = 0;
                m_pending     = 1'b0;
            end
            if (d[0]) begin
                check("waitreq_capture", 32'(avs_waitrequest), 32'd1);
                @(negedge clk);
                check("waitreq_release", 32'(avs_waitrequest), 32'd0);
                model_snapshot();
            end
        end
    endtask

    task automatic pulse_row();
        row_cleared = 1'b1;
        @(negedge clk);
        row_cleared = 1'b0;
        @(negedge clk);
        model_line();
    endtask

    task automatic check_irq(input string name);
        @(negedge clk);
        check(name, 32'(irq), 32'(m_irq_en & m_pending));
    endtask

    task automatic random_grid();
        for (int b = 0; b < int'(R*C); b++) grid_state[b] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] d, d2;

        reset = 1'b1; grid_state = '0; row_cleared = 1'b0; game_over = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_rdvalid", 32'(avs_readdatavalid), 32'd0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back reads of every mapped word straight out of reset.
        for (int i = 0; i < int'(R) + 4; i++) begin
            avs_address = 5'(i);
            avs_read    = 1'b1;
            @(negedge clk);
            check($sformatf("b2b_valid_a%0d", i), 32'(avs_readdatavalid), 32'd1);
            check($sformatf("b2b_data_a%0d", i), avs_readdata, 32'd0);
        end
        avs_read = 1'b0;
        @(negedge clk);
        check("b2b_valid_drop", 32'(avs_readdatavalid), 32'd0);

        // First snapshot of a known pattern.
        grid_state = '0;
        grid_state[4] = 1'b1;
        grid_state[19*C +: C] = '1;
        bus_write(ADDR_CTRL, 32'h1);
        tbl.push_back('{addr: 5'd0,               exp: 32'h010});
        tbl.push_back('{addr: 5'd19,              exp: 32'h3FF});
        tbl.push_back('{addr: 5'd1,               exp: 32'h000});
        tbl.push_back('{addr: 5'd10,              exp: 32'h000});
        tbl.push_back('{addr: 5'(ADDR_STATUS),    exp: 32'h001});
        tbl.push_back('{addr: 5'(ADDR_LINES),     exp: 32'h000});
        tbl.push_back('{addr: 5'(ADDR_CTRL),      exp: 32'h000});
        tbl.push_back('{addr: 5'(ADDR_GEN),       exp: 32'h001});
        tbl.push_back('{addr: 5'd24,              exp: 32'h000});
        tbl.push_back('{addr: 5'd31,              exp: 32'h000});
        foreach (tbl[k]) begin
            do_read(int'(tbl[k].addr), d, d2);
            check($sformatf("tbl_a%0d", tbl[k].addr), d, tbl[k].exp);
        end

        // Live grid changes must not leak into the held frame.
        random_grid();
        @(negedge clk);
        do_read(0, d, d2);
        check("hold_row0", d, 32'h010);
        do_read(19, d, d2);
        check("hold_row19", d, 32'h3FF);
        read_check(7);

        // Read and write together: write lands, read is dropped.
        avs_address = 5'(ADDR_CTRL); avs_writedata = 32'h2;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        check("rw_no_valid", 32'(avs_readdatavalid), 32'd0);
        m_irq_en = 1'b1;
        read_check(ADDR_CTRL);

        // Three cleared lines with irq enabled.
        repeat (3) pulse_row();
        check_irq("irq_lines3_model");
        check("irq_lines3", 32'(irq), 32'd1);
        do_read(ADDR_LINES, d, d2);
        check("lines3", d, 32'd3);
        bus_write(ADDR_CTRL, 32'h6);
        check_irq("irq_after_clr_model");
        check("irq_after_clr", 32'(irq), 32'd0);
        do_read(ADDR_LINES, d, d2);
        check("lines_after_clr", d, 32'd0);

        // Clear coinciding with a row_cleared edge: the event survives.
        repeat (2) pulse_row();
        avs_address = 5'(ADDR_CTRL); avs_writedata = 32'h6; avs_write = 1'b1;
        row_cleared = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; row_cleared = 1'b0;
        @(negedge clk);
        m_lines = 1; m_lines_small = 1; m_pending = 1'b1; m_irq_en = 1'b1;
        do_read(ADDR_LINES, d, d2);
        check("clr_vs_event", d, 32'd1);
        read_check(ADDR_STATUS);
        check_irq("irq_clr_vs_event");

        // Saturation on the narrow instance, plain counting on the wide one.
        bus_write(ADDR_CTRL, 32'h4);
        repeat (20) pulse_row();
        do_read(ADDR_LINES, d, d2);
        check("lines20", d, 32'd20);
        check("lines_small_sat", d2, 32'd15);

        // Randomized operations against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: begin random_grid(); @(negedge clk); end
                1: bus_write(ADDR_CTRL, 32'($urandom_range(0, 7)));
                2, 3: read_check(int'($urandom_range(0, 31)));
                4: pulse_row();
                default: begin
                    game_over = ~game_over;
                    if (game_over) m_pending = 1'b1;
                    @(negedge clk);
                end
            endcase
            check_irq("irq_rand");
        end

        // Reset while a readdatavalid is due.
        game_over = 1'b0;
        @(negedge clk);
        avs_address = 5'(ADDR_GEN); avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_kills_valid", 32'(avs_readdatavalid), 32'd0);
        check("rst_kills_data", avs_readdata, 32'd0);
        check("rst_kills_irq", 32'(irq), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during CAPTURE.
        grid_state = '1;
        avs_address = 5'(ADDR_CTRL); avs_writedata = 32'h3; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        check("cap_waitreq", 32'(avs_waitrequest), 32'd1);
        reset = 1'b1;
        #1;
        check("cap_rst_waitreq", 32'(avs_waitrequest), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("cap_rst_no_valid", 32'(avs_readdatavalid), 32'd0);
        do_read(ADDR_STATUS, d, d2);
        check("cap_rst_status", d, 32'd0);
        do_read(ADDR_GEN, d, d2);
        check("cap_rst_gen", d, 32'd0);
        do_read(19, d, d2);
        check("cap_rst_row19", d, 32'd0);
        game_over = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_read(ADDR_STATUS, d, d2);
        check("go_pending", d, 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
